imem_loader: RTL

Writer-side companion to the instruction memory: accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them sequentially into instruction memory through its write port. Holds the pipeline in reset until the image is fully loaded. Sits between the boot/debug byte source and the instruction memory, which is read-only from the fetch stage.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_word_assembler.sv | 31 +++
 rtl/imem_loader.sv | 123 ++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and constants for the instruction memory loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int DEFAULT_DEPTH = 1024;
  localparam int BYTE_LANES    = 4;
  localparam int LANE_W        = $clog2(BYTE_LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTE_LANES - 1);

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in and instruction memory write port out
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/imem_word_assembler.sv
// rtl/imem_word_assembler.sv - packs accepted bytes into little-endian 32-bit words
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_data,
  input  logic        byte_fire,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [LANE_W-1:0] lane_q;
  logic [23:0]       sh_q;

  // The completed word is presented combinationally with the 4th byte so the
  // caller can register it in the same edge that accepts that byte.
  assign word_valid = byte_fire && (lane_q == LAST_LANE);
  assign word       = {byte_data, sh_q};

  always_ff @(posedge clk) begin
    if (!rst) begin
      lane_q <= '0;
      sh_q   <= '0;
    end else if (byte_fire) begin
      lane_q <= lane_q + LANE_W'(1);
      sh_q   <= {byte_data, sh_q[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a length-prefixed byte image into instruction memory and holds the CPU in reset until done
// Optional trailing XOR checksum enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  imem_loader_if.slave     bus,
  output logic             cpu_rst,
  output logic             load_done,
  output logic             load_err,
  output logic [CNT_W-1:0] words_loaded
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_q;
  logic             wr_en_q;
  logic [31:0]      wr_addr_q;
  logic [31:0]      wr_data_q;
  logic [31:0]      word;
  logic             word_valid;
  logic             byte_fire;
  logic             accepting;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]      csum_q;
`endif

  imem_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_data  (bus.rx_data),
    .byte_fire  (byte_fire),
    .word       (word),
    .word_valid (word_valid)
  );

  // In DATA, once the last word has been counted the loader stops accepting
  // so that trailing bytes cannot slip in during the final write cycle.
  assign accepting = (state_q == ST_HDR)
                  || (state_q == ST_DATA && words_loaded != n_q)
                  || (state_q == ST_CSUM);
  assign bus.rx_ready = rst && accepting;
  assign byte_fire    = bus.rx_valid && bus.rx_ready;

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

  assign cpu_rst   = (state_q != ST_DONE);
  assign load_done = (state_q == ST_DONE);
  assign load_err  = (state_q == ST_ERR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HDR: begin
        if (word_valid) begin
          if (word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
`endif
          end else if (word > 32'(DEPTH)) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (word_valid && words_loaded == n_q - CNT_W'(1)) state_d = ST_CSUM;
`else
        if (words_loaded == n_q) state_d = ST_DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (word_valid) state_d = (word == csum_q) ? ST_DONE : ST_ERR;
      end
`endif
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_HDR;
      n_q          <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      words_loaded <= '0;
    end else begin
      state_q <= state_d;
      wr_en_q <= 1'b0;
      if (state_q == ST_HDR && word_valid) n_q <= word[CNT_W-1:0];
      if (state_q == ST_DATA && word_valid) begin
        wr_en_q      <= 1'b1;
        wr_addr_q    <= 32'({words_loaded, 2'b00});
        wr_data_q    <= word;
        words_loaded <= words_loaded + CNT_W'(1);
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      csum_q <= '0;
    end else if (state_q == ST_HDR) begin
      csum_q <= '0;
    end else if (state_q == ST_DATA && word_valid) begin
      csum_q <= csum_q ^ word;
    end
  end
`endif

endmodule
